// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and its datapath muxes.
// States, opcodes/functs, select encodings and the decoded instruction class.
package mc_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_MEMWB  = 3'd4;
  localparam logic [2:0] ST_ALUWB  = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  typedef struct packed {
    logic rtype_alu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath signal bundle: IR fields and Zero in, enables and selects out.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic       IRWr;
  logic [1:0] NPCSel;
  logic       RegWr;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic       ALUSrc;
  logic [1:0] ExtOp;
  logic [2:0] ALUOp;
  logic       MemWr;
  logic       Retire;
  logic       Illegal;
  logic [2:0] State;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, IRWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp,
           MemWr, Retire, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, IRWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp,
           MemWr, Retire, Illegal, State
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct to one-hot instruction class; anything unknown is illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output insn_class_t cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
          FN_JR:            cls.jr        = 1'b1;
          FN_NOP:           cls.nop       = 1'b1;
          default:          cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: state register plus per-state enables/selects for PC, IR, GPR, DM.
// Outputs are combinational from state and IR fields, and forced low while Reset is high.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset,
  mc_ctrl_if.master bus
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  insn_class_t cls;

  logic       pc_wr;
  logic       ir_wr;
  logic [1:0] npc_sel;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       mem_wr;
  logic       retire;
  logic       illegal;

  mc_ctrl_decode u_decode (
    .op    (bus.Op),
    .funct (bus.Funct),
    .cls   (cls)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    npc_sel = NPC_PC4;
    reg_wr  = 1'b0;
    reg_dst = RD_RT;
    wd_sel  = WD_ALU;
    alu_src = 1'b0;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    mem_wr  = 1'b0;
    retire  = 1'b0;
    illegal = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          // jal writes the pre-edge PC, which already holds the fetched PC+4
          if (cls.j || cls.jal) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JUMP;
            retire  = 1'b1;
          end
          if (cls.jal) begin
            reg_wr  = 1'b1;
            reg_dst = RD_RA;
            wd_sel  = WD_PC;
          end
          if (cls.jr) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_REG;
            retire  = 1'b1;
          end
          if (cls.nop) retire = 1'b1;
          if (cls.illegal) begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
          if (!retire) state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (cls.rtype_alu) begin
            alu_op  = (bus.Funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            state_d = ST_ALUWB;
          end else if (cls.ori || cls.lui) begin
            alu_src = 1'b1;
            ext_op  = cls.lui ? EXT_LUI : EXT_ZERO;
            alu_op  = ALU_OR;
            state_d = ST_ALUWB;
          end else if (cls.lw || cls.sw) begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
            state_d = ST_MEM;
          end else if (cls.beq) begin
            alu_op  = ALU_SUB;
            ext_op  = EXT_SIGN;
            retire  = 1'b1;
            if (bus.Zero) begin
              pc_wr   = 1'b1;
              npc_sel = NPC_BRANCH;
            end
          end
        end
        ST_MEM: begin
          if (cls.sw) begin
            mem_wr = 1'b1;
            retire = 1'b1;
          end else if (cls.lw) begin
            state_d = ST_MEMWB;
          end
        end
        ST_MEMWB: begin
          reg_wr  = 1'b1;
          reg_dst = RD_RT;
          wd_sel  = WD_DM;
          retire  = 1'b1;
        end
        ST_ALUWB: begin
          reg_wr  = 1'b1;
          reg_dst = cls.rtype_alu ? RD_RD : RD_RT;
          wd_sel  = WD_ALU;
          retire  = 1'b1;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign bus.PCWr    = pc_wr;
  assign bus.IRWr    = ir_wr;
  assign bus.NPCSel  = npc_sel;
  assign bus.RegWr   = reg_wr;
  assign bus.RegDst  = reg_dst;
  assign bus.WDSel   = wd_sel;
  assign bus.ALUSrc  = alu_src;
  assign bus.ExtOp   = ext_op;
  assign bus.ALUOp   = alu_op;
  assign bus.MemWr   = mem_wr;
  assign bus.Retire  = retire;
  assign bus.Illegal = illegal;
  assign bus.State   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle against hand-built
// control words {PCWr,IRWr,NPCSel,RegWr,RegDst,WDSel,ALUSrc,ExtOp,ALUOp,MemWr,Retire,Illegal}.
module tb_mc_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   rcnt;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  localparam logic [17:0] C_NONE  = 18'b0_0_00_0_00_00_0_00_000_0_0_0;
  localparam logic [17:0] C_FETCH = 18'b1_1_00_0_00_00_0_00_000_0_0_0;

  logic [17:0] obs;
  assign obs = {bus.PCWr, bus.IRWr, bus.NPCSel, bus.RegWr, bus.RegDst, bus.WDSel,
                bus.ALUSrc, bus.ExtOp, bus.ALUOp, bus.MemWr, bus.Retire, bus.Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // check state and control word now, then move to the next sample point
  task automatic step(input string tag, input logic [2:0] st, input logic [17:0] cw);
    check({tag, "_st"}, 32'(bus.State), 32'(st));
    check({tag, "_cw"}, 32'(obs), 32'(cw));
    if (bus.Retire === 1'b1) rcnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.Op    = op;
    bus.Funct = fn;
    bus.Zero  = z;
    rcnt      = 0;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rcnt      = 0;
    reset     = 1'b1;
    bus.Op    = 6'b100011;
    bus.Funct = 6'b0;
    bus.Zero  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_st", 32'(bus.State), 32'd0);
    check("rst_hold_cw", 32'(obs), 32'(C_NONE));
    @(negedge clk);
    reset = 1'b0;
    #1;

    // addu
    set_ir(6'b000000, 6'b100001, 1'b0);
    step("addu_f", 3'd0, C_FETCH);
    step("addu_d", 3'd1, C_NONE);
    step("addu_e", 3'd2, 18'b0_0_00_0_00_00_0_00_000_0_0_0);
    step("addu_w", 3'd5, 18'b0_0_00_1_01_00_0_00_000_0_1_0);
    check("addu_ret", 32'(rcnt), 32'd1);

    // subu
    set_ir(6'b000000, 6'b100011, 1'b1);
    step("subu_f", 3'd0, C_FETCH);
    step("subu_d", 3'd1, C_NONE);
    step("subu_e", 3'd2, 18'b0_0_00_0_00_00_0_00_001_0_0_0);
    step("subu_w", 3'd5, 18'b0_0_00_1_01_00_0_00_000_0_1_0);

    // ori, with Zero high to confirm it is ignored outside beq
    set_ir(6'b001101, 6'b100001, 1'b1);
    step("ori_f", 3'd0, C_FETCH);
    step("ori_d", 3'd1, C_NONE);
    step("ori_e", 3'd2, 18'b0_0_00_0_00_00_1_00_010_0_0_0);
    step("ori_w", 3'd5, 18'b0_0_00_1_00_00_0_00_000_0_1_0);

    // lui
    set_ir(6'b001111, 6'b000000, 1'b0);
    step("lui_f", 3'd0, C_FETCH);
    step("lui_d", 3'd1, C_NONE);
    step("lui_e", 3'd2, 18'b0_0_00_0_00_00_1_10_010_0_0_0);
    step("lui_w", 3'd5, 18'b0_0_00_1_00_00_0_00_000_0_1_0);

    // lw
    set_ir(6'b100011, 6'b000000, 1'b0);
    step("lw_f", 3'd0, C_FETCH);
    step("lw_d", 3'd1, C_NONE);
    step("lw_e", 3'd2, 18'b0_0_00_0_00_00_1_01_000_0_0_0);
    step("lw_m", 3'd3, C_NONE);
    step("lw_wb", 3'd4, 18'b0_0_00_1_00_01_0_00_000_0_1_0);
    check("lw_ret", 32'(rcnt), 32'd1);

    // sw
    set_ir(6'b101011, 6'b000000, 1'b1);
    step("sw_f", 3'd0, C_FETCH);
    step("sw_d", 3'd1, C_NONE);
    step("sw_e", 3'd2, 18'b0_0_00_0_00_00_1_01_000_0_0_0);
    step("sw_m", 3'd3, 18'b0_0_00_0_00_00_0_00_000_1_1_0);

    // beq taken / not taken
    set_ir(6'b000100, 6'b000000, 1'b1);
    step("beq1_f", 3'd0, C_FETCH);
    step("beq1_d", 3'd1, C_NONE);
    step("beq1_e", 3'd2, 18'b1_0_01_0_00_00_0_01_001_0_1_0);
    set_ir(6'b000100, 6'b000000, 1'b0);
    step("beq0_f", 3'd0, C_FETCH);
    step("beq0_d", 3'd1, C_NONE);
    step("beq0_e", 3'd2, 18'b0_0_00_0_00_00_0_01_001_0_1_0);

    // j, jal, jr
    set_ir(6'b000010, 6'b000000, 1'b0);
    step("j_f", 3'd0, C_FETCH);
    step("j_d", 3'd1, 18'b1_0_10_0_00_00_0_00_000_0_1_0);
    set_ir(6'b000011, 6'b000000, 1'b1);
    step("jal_f", 3'd0, C_FETCH);
    step("jal_d", 3'd1, 18'b1_0_10_1_10_10_0_00_000_0_1_0);
    set_ir(6'b000000, 6'b001000, 1'b0);
    step("jr_f", 3'd0, C_FETCH);
    step("jr_d", 3'd1, 18'b1_0_11_0_00_00_0_00_000_0_1_0);

    // illegal opcode and illegal R-type funct
    set_ir(6'b111111, 6'b000000, 1'b0);
    step("ill_f", 3'd0, C_FETCH);
    step("ill_d", 3'd1, 18'b0_0_00_0_00_00_0_00_000_0_1_1);
    set_ir(6'b000000, 6'b000001, 1'b0);
    step("illr_f", 3'd0, C_FETCH);
    step("illr_d", 3'd1, 18'b0_0_00_0_00_00_0_00_000_0_1_1);

    // nop, then an unused state code while in DECODE
    set_ir(6'b000000, 6'b000000, 1'b0);
    step("nop_f", 3'd0, C_FETCH);
    check("nop_d_st", 32'(bus.State), 32'd1);
    check("nop_d_cw", 32'(obs), 32'(18'b0_0_00_0_00_00_0_00_000_0_1_0));
    force dut.state_q = 3'd7;
    #1;
    check("code7_st", 32'(bus.State), 32'd7);
    check("code7_cw", 32'(obs), 32'(C_NONE));
    release dut.state_q;
    @(negedge clk);
    #1;

    // reset mid-EXEC of lw
    set_ir(6'b100011, 6'b000000, 1'b0);
    step("lwr_f", 3'd0, C_FETCH);
    step("lwr_d", 3'd1, C_NONE);
    check("lwr_e_cw", 32'(obs), 32'(18'b0_0_00_0_00_00_1_01_000_0_0_0));
    #1;
    reset = 1'b1;
    #1;
    check("lwr_rst_st", 32'(bus.State), 32'd0);
    check("lwr_rst_cw", 32'(obs), 32'(C_NONE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    step("lwr2_f", 3'd0, C_FETCH);
    step("lwr2_d", 3'd1, C_NONE);
    step("lwr2_e", 3'd2, 18'b0_0_00_0_00_00_1_01_000_0_0_0);
    step("lwr2_m", 3'd3, C_NONE);
    step("lwr2_wb", 3'd4, 18'b0_0_00_1_00_01_0_00_000_0_1_0);
    step("lwr2_end", 3'd0, C_FETCH);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS-subset CPU. It sequences the instruction-fetch unit, register file, ALU and data memory across FETCH/DECODE/EXEC/MEM/WB steps, and generates the per-cycle write enables and mux selects from the latched opcode/funct and the ALU zero flag. It sits beside the datapath and owns every architectural state update: PC, IR, GPR and DM.

## Interface
Parameters:
- none (all encodings live in `mc_ctrl_pkg`)

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Op  in  6  IR[31:26]; driven from the IR register, so it is stable from DECODE until the next FETCH edge.
- Funct  in  6  IR[5:0]; same stability as Op.
- Zero  in  1  ALU result == 0; sampled combinationally in EXEC.
- PCWr  out  1  PC register load enable.
- IRWr  out  1  IR load enable.
- NPCSel  out  2  next-PC select: 00 PC+4, 01 branch (PC + sext(imm)<<2), 10 {PC[31:28],IR[25:0],00}, 11 GPR[rs].
- RegWr  out  1  GPR write enable.
- RegDst  out  2  write address: 00 rt, 01 rd, 10 $31.
- WDSel  out  2  GPR write data: 00 ALU result, 01 DM read data, 10 current PC register.
- ALUSrc  out  1  ALU B operand: 0 GPR[rt], 1 extended immediate.
- ExtOp  out  2  immediate extension: 00 zero-extend, 01 sign-extend, 10 imm<<16.
- ALUOp  out  3  ALU function: 000 add, 001 sub, 010 or.
- MemWr  out  1  DM write enable.
- Retire  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode/funct is unsupported.
- State  out  3  current state, for debug.

## Operation
States: FETCH=0, DECODE=1, EXEC=2, MEM=3, MEMWB=4, ALUWB=5. Codes 6 and 7 go to FETCH on the next edge with all enables at 0.

Supported opcodes and functs:
- R-type (Op 000000): addu (funct 100001), subu (funct 100011), jr (funct 001000), nop (funct 000000).
- I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.

Per-state behaviour:
- **FETCH:** IRWr=1, PCWr=1, NPCSel=00. Go to DECODE.
- **DECODE:** the PC register already holds the fetched PC+4.
  - j: PCWr=1, NPCSel=10, Retire. Go to FETCH.
  - jal: as j, plus RegWr=1, RegDst=10, WDSel=10. The GPR write uses the pre-edge PC, i.e. the return address is the fetched PC+4.
  - jr: PCWr=1, NPCSel=11, Retire. Go to FETCH.
  - nop: Retire. Go to FETCH.
  - Unsupported encoding: Illegal=1, Retire=1, no writes. Go to FETCH.
  - All others: go to EXEC.
- **EXEC:**
  - addu/subu: ALUSrc=0, ALUOp add/sub. Go to ALUWB.
  - ori: ALUSrc=1, ExtOp=00, ALUOp=or. Go to ALUWB.
  - lui: ALUSrc=1, ExtOp=10, ALUOp=or. Go to ALUWB.
  - lw/sw: ALUSrc=1, ExtOp=01, ALUOp=add. Go to MEM.
  - beq: ALUSrc=0, ALUOp=sub, ExtOp=01, Retire. If Zero, PCWr=1 and NPCSel=01. Go to FETCH.
- **MEM:**
  - sw: MemWr=1, Retire. Go to FETCH.
  - lw: go to MEMWB.
- **MEMWB:** RegWr=1, RegDst=00, WDSel=01, Retire. Go to FETCH.
- **ALUWB:** RegWr=1, RegDst=01 for R-type and 00 otherwise, WDSel=00, Retire. Go to FETCH.

Output rules:
- Every enable not listed for a state is 0.
- Selects not listed for a state are 0.

## Timing
- Reset asserted at any time forces State=FETCH immediately (asynchronous).
  - While Reset is high, every output is 0 except State=0.
  - An instruction in flight is abandoned with no partial write.
- First FETCH edge is the first rising Clk edge after Reset deasserts.
- Outputs are combinational from State, Op, Funct and Zero; there are no registered outputs.
- Cycles per instruction:
  - j/jal/jr/nop/illegal: 2.
  - beq: 3.
  - sw, addu/subu/ori/lui: 4.
  - lw: 5.
- Retire fires exactly once per instruction, in its last cycle.
- beq with Zero=0 leaves PC at the fetched PC+4.
- Zero is used only in EXEC for beq; it is ignored in every other state and for every other opcode.

## Structure
- `mc_ctrl_pkg` holds:
  - opcode and funct constants;
  - state encoding;
  - NPCSel, RegDst, WDSel, ExtOp and ALUOp encodings.

  The datapath muxes import the same package.
- Sub-module `mc_ctrl_decode`: purely combinational. It maps Op/Funct to a one-hot instruction class (rtype_alu, jr, nop, ori, lui, lw, sw, beq, j, jal, illegal). `mc_ctrl` holds the state register and the per-state output logic.

## Test plan
- Reset mid-EXEC of lw, then release → State=0 at once, RegWr=MemWr=PCWr=0, next edge FETCH asserts IRWr=PCWr with NPCSel=00.
- addu (Op 000000, Funct 100001) → states 0,1,2,5. RegWr only in state 5 with RegDst=01, WDSel=00. Exactly one Retire over 4 cycles.
- lw (Op 100011) → states 0,1,2,3,4. ExtOp=01 in EXEC. RegWr with WDSel=01, RegDst=00 only in state 4. Retire on cycle 5.
- beq (Op 000100) twice: Zero=1 → PCWr=1, NPCSel=01 in EXEC. Zero=0 → PCWr=0. Both return to FETCH after 3 cycles.
- jal (Op 000011) → DECODE asserts PCWr=1, NPCSel=10, RegWr=1, RegDst=10, WDSel=10 in the same cycle. 2-cycle instruction.
- Op 111111 → Illegal and Retire pulse in DECODE, no enables, back to FETCH. Forcing State to code 7 returns to FETCH in one cycle.
